// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NREQ byte-stream requesters.
// The grant is held for a whole message (until req_last), with an optional idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [8*NREQ-1:0]         req_data_i,
  input  logic [NREQ-1:0]           req_last_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic                      grant_valid_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o,
  output logic                      timeout_pulse_o
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_pulse_q, timeout_pulse_d;

  logic [7:0]      req_byte [NREQ];
  logic            win_found;
  logic [IdW-1:0]  win_id;
  logic [IdW-1:0]  cand_id;
  int unsigned     cand;
  logic            g_valid;
  logic            g_last;
  logic            handshake;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_data_i[8*gi +: 8];
  end

  // First requesting index after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_id = IdW'(cand);
      if (!win_found && req_valid_i[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign g_valid   = req_valid_i[grant_id_q];
  assign g_last    = req_last_i[grant_id_q];
  assign handshake = g_valid & tx_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= IdW'(NREQ - 1);
      grant_id_q      <= '0;
      grant_valid_q   <= 1'b0;
      idle_cnt_q      <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      grant_valid_q   <= grant_valid_d;
      idle_cnt_q      <= idle_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  // Next-state logic plus the combinational pass-through of the owner's stream.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    grant_valid_d   = grant_valid_q;
    idle_cnt_d      = idle_cnt_q;
    timeout_pulse_d = 1'b0;
    tx_valid_o      = 1'b0;
    tx_data_o       = '0;
    req_ready_o     = '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          idle_cnt_d    = '0;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        tx_valid_o  = g_valid;
        tx_data_o   = req_byte[grant_id_q];
        req_ready_o = NREQ'(tx_ready_i) << grant_id_q;
        if (handshake) begin
          idle_cnt_d = '0;
          if (g_last) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = grant_id_q;
            state_d       = IDLE;
          end
        end else if (!g_valid) begin
          // A stalled serializer never counts as idle; only a silent owner does.
          if ((TIMEOUT != 0) && (idle_cnt_q == CntW'(TIMEOUT - 1))) begin
            timeout_pulse_d = 1'b1;
            grant_valid_d   = 1'b0;
            rr_ptr_d        = grant_id_q;
            state_d         = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid_o   = grant_valid_q;
  assign grant_id_o      = grant_id_q;
  assign timeout_pulse_o = timeout_pulse_q;

endmodule
